// File: rtl/matmul_sequencer_if.sv
// Control and memory bus of the matrix-multiply sequencer.
// master: the sequencer itself; slave: the control unit and the memories.
interface matmul_sequencer_if #(
    parameter int ADDR_W = 7,
    parameter int ACC_W  = 16
) ();
    logic              start;
    logic [3:0]        size;
    logic              abort;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic              rd_en;
    logic [7:0]        a_rdata;
    logic [7:0]        b_rdata;
    logic [ADDR_W-1:0] res_addr;
    logic [ACC_W-1:0]  res_wdata;
    logic              res_we;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, size, abort, a_rdata, b_rdata,
        output a_addr, b_addr, rd_en, res_addr, res_wdata, res_we, busy, done, err
    );

    modport slave (
        output start, size, abort, a_rdata, b_rdata,
        input  a_addr, b_addr, rd_en, res_addr, res_wdata, res_we, busy, done, err
    );
endinterface

// File: rtl/matmul_sequencer.sv
// Time-multiplexed NxN matrix multiply: one 8x8 MAC walks the i/j/k loops.
// Define SATURATE_EN to clamp the accumulator at all ones instead of wrapping.
module matmul_sequencer #(
    parameter int MAX_N  = 10,
    parameter int ADDR_W = 7,
    parameter int ACC_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    matmul_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(MAX_N);

    state_t            state_r, state_s;
    logic [3:0]        n_r, n_s, i_r, i_s, j_r, j_s, k_r, k_s;
    logic [ACC_W-1:0]  acc_r, acc_s, acc_upd_s;
    logic              vld_r, vld_s;
    logic [ADDR_W-1:0] a_addr_r, a_addr_s, b_addr_r, b_addr_s, res_addr_r, res_addr_s;
    logic [ACC_W-1:0]  res_wdata_r, res_wdata_s;
    logic              rd_en_r, rd_en_s, res_we_r, res_we_s;
    logic              busy_r, busy_s, done_r, done_s, err_r, err_s;
    logic [15:0]       prod_s;
    logic              size_ok_s;

    function automatic logic [ACC_W-1:0] acc_add(input logic [ACC_W-1:0] a,
                                                 input logic [15:0] p);
`ifdef SATURATE_EN
        logic [ACC_W:0] s;
        s = {1'b0, a} + (ACC_W+1)'(p);
        if (s[ACC_W]) begin
            acc_add = {ACC_W{1'b1}};
        end else begin
            acc_add = s[ACC_W-1:0];
        end
`else
        acc_add = a + ACC_W'(p);
`endif
    endfunction

    assign prod_s    = {8'd0, bus.a_rdata} * {8'd0, bus.b_rdata};
    assign size_ok_s = (bus.size != 4'd0) && ({28'd0, bus.size} <= 32'(MAX_N));
    // vld_r marks that read data from the previous strobe is on the bus this cycle
    assign acc_upd_s = vld_r ? acc_add(acc_r, prod_s) : acc_r;

    // Next-state and next-output logic
    always_comb begin
        state_s     = state_r;
        n_s         = n_r;
        i_s         = i_r;
        j_s         = j_r;
        k_s         = k_r;
        acc_s       = acc_r;
        vld_s       = rd_en_r;
        a_addr_s    = a_addr_r;
        b_addr_s    = b_addr_r;
        res_addr_s  = res_addr_r;
        res_wdata_s = res_wdata_r;
        rd_en_s     = 1'b0;
        res_we_s    = 1'b0;
        busy_s      = busy_r;
        done_s      = 1'b0;
        err_s       = 1'b0;
        if (bus.abort && (state_r != S_IDLE)) begin
            state_s = S_IDLE;
            busy_s  = 1'b0;
            vld_s   = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        if (size_ok_s) begin
                            n_s     = bus.size;
                            i_s     = 4'd0;
                            j_s     = 4'd0;
                            k_s     = 4'd0;
                            acc_s   = {ACC_W{1'b0}};
                            busy_s  = 1'b1;
                            state_s = S_RUN;
                        end else begin
                            err_s = 1'b1;
                        end
                    end else begin
                        state_s = S_IDLE;
                    end
                end
                S_RUN: begin
                    rd_en_s  = 1'b1;
                    a_addr_s = ADDR_W'(i_r) * STRIDE + ADDR_W'(k_r);
                    b_addr_s = ADDR_W'(k_r) * STRIDE + ADDR_W'(j_r);
                    acc_s    = acc_upd_s;
                    if (k_r == (n_r - 4'd1)) begin
                        state_s = S_DRAIN;
                    end else begin
                        k_s = k_r + 4'd1;
                    end
                end
                S_DRAIN: begin
                    acc_s   = acc_upd_s;
                    state_s = S_WRITE;
                end
                S_WRITE: begin
                    res_we_s    = 1'b1;
                    res_wdata_s = acc_upd_s;
                    res_addr_s  = ADDR_W'(i_r) * STRIDE + ADDR_W'(j_r);
                    acc_s       = {ACC_W{1'b0}};
                    k_s         = 4'd0;
                    if (j_r == (n_r - 4'd1)) begin
                        j_s = 4'd0;
                        if (i_r == (n_r - 4'd1)) begin
                            i_s     = 4'd0;
                            state_s = S_DONE;
                        end else begin
                            i_s     = i_r + 4'd1;
                            state_s = S_RUN;
                        end
                    end else begin
                        j_s     = j_r + 4'd1;
                        state_s = S_RUN;
                    end
                end
                S_DONE: begin
                    done_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = S_IDLE;
                end
                default: begin
                    busy_s  = 1'b0;
                    state_s = S_IDLE;
                end
            endcase
        end
    end

    // State, loop counters, accumulator and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            n_r         <= 4'd0;
            i_r         <= 4'd0;
            j_r         <= 4'd0;
            k_r         <= 4'd0;
            acc_r       <= {ACC_W{1'b0}};
            vld_r       <= 1'b0;
            a_addr_r    <= {ADDR_W{1'b0}};
            b_addr_r    <= {ADDR_W{1'b0}};
            res_addr_r  <= {ADDR_W{1'b0}};
            res_wdata_r <= {ACC_W{1'b0}};
            rd_en_r     <= 1'b0;
            res_we_r    <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            n_r         <= n_s;
            i_r         <= i_s;
            j_r         <= j_s;
            k_r         <= k_s;
            acc_r       <= acc_s;
            vld_r       <= vld_s;
            a_addr_r    <= a_addr_s;
            b_addr_r    <= b_addr_s;
            res_addr_r  <= res_addr_s;
            res_wdata_r <= res_wdata_s;
            rd_en_r     <= rd_en_s;
            res_we_r    <= res_we_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            err_r       <= err_s;
        end
    end

    assign bus.a_addr    = a_addr_r;
    assign bus.b_addr    = b_addr_r;
    assign bus.rd_en     = rd_en_r;
    assign bus.res_addr  = res_addr_r;
    assign bus.res_wdata = res_wdata_r;
    assign bus.res_we    = res_we_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_matmul_sequencer.sv
// Scoreboard bench for matmul_sequencer: a reference matrix product fills a
// queue of expected writes that a result-bus monitor pops and compares.
module tb_matmul_sequencer;

    localparam int MAX_N = 10;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   we_cnt;

    logic [7:0] mem_a [128];
    logic [7:0] mem_b [128];
    logic [31:0] exp_q [$];

    matmul_sequencer_if #(.ADDR_W(7), .ACC_W(16)) bus ();

    matmul_sequencer #(.MAX_N(10), .ADDR_W(7), .ACC_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Memory model with a one-cycle registered read
    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.a_rdata <= mem_a[bus.a_addr];
            bus.b_rdata <= mem_b[bus.b_addr];
        end
    end

    // Result-bus monitor
    always @(negedge clk) begin
        if (!rst && bus.res_we) begin
            logic [31:0] e;
            we_cnt++;
            if (bus.rd_en) chk("we_with_rd_en", 32'd1, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {25'd0, bus.res_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("res_addr", {25'd0, bus.res_addr}, {16'd0, e[31:16]});
                chk("res_wdata", {16'd0, bus.res_wdata}, {16'd0, e[15:0]});
            end
        end
    end

    function automatic logic [15:0] ref_elem(input int n, input int i, input int j);
        longint sum;
        sum = 0;
        for (int k = 0; k < n; k++) sum += mem_a[i*MAX_N+k] * mem_b[k*MAX_N+j];
`ifdef SATURATE_EN
        if (sum > 65535) sum = 65535;
`endif
        return sum[15:0];
    endfunction

    task automatic push_expect(input int n, input int count);
        int c;
        c = 0;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                if (c < count) begin
                    exp_q.push_back({16'(i*MAX_N+j), ref_elem(n, i, j)});
                    c++;
                end
    endtask

    // Full multiply; optional ignored start/size change mid-run
    task automatic run_mul(input int n, input int exp_cyc, input bit poke);
        int cyc;
        int busy_bad;
        push_expect(n, n*n);
        @(negedge clk);
        bus.size  = 4'(n);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc = 0;
        busy_bad = 0;
        while (!bus.done && cyc < 3000) begin
            @(posedge clk);
            #1;
            cyc++;
            if (poke && cyc == 5) begin
                bus.start = 1'b1;
                bus.size  = 4'd5;
            end else begin
                bus.start = 1'b0;
            end
            if (!bus.done && !bus.busy) busy_bad++;
        end
        chk("done_seen", {31'd0, bus.done}, 32'd1);
        chk("done_latency", cyc, exp_cyc);
        chk("busy_during_run", busy_bad, 32'd0);
        chk("busy_low_at_done", {31'd0, bus.busy}, 32'd0);
        @(posedge clk);
        #1 chk("done_pulse_width", {31'd0, bus.done}, 32'd0);
        repeat (2) @(posedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
    endtask

    task automatic err_test(input logic [3:0] sz);
        int we0;
        int rd_seen;
        we0 = we_cnt;
        rd_seen = 0;
        @(negedge clk);
        bus.size  = sz;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        chk("err_pulse", {31'd0, bus.err}, 32'd1);
        chk("err_busy", {31'd0, bus.busy}, 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (bus.rd_en || bus.busy || bus.err) rd_seen++;
        end
        chk("err_quiet_after", rd_seen, 32'd0);
        chk("err_no_writes", we_cnt - we0, 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        we_cnt = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.size = 4'd0;
        bus.abort = 1'b0;
        bus.a_rdata = 8'd0;
        bus.b_rdata = 8'd0;
        for (int a = 0; a < 128; a++) begin
            mem_a[a] = 8'(a * 3 + 1);
            mem_b[a] = 8'(a * 7 + 2);
        end
        #12;
        chk("reset_outputs", {bus.a_addr, bus.b_addr, bus.res_addr, bus.res_wdata,
                              bus.rd_en, bus.res_we, bus.busy, bus.done, bus.err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // N=2 worked example
        mem_a[0] = 8'd1; mem_a[1] = 8'd2; mem_a[10] = 8'd3; mem_a[11] = 8'd4;
        mem_b[0] = 8'd5; mem_b[1] = 8'd6; mem_b[10] = 8'd7; mem_b[11] = 8'd8;
        chk("ref_model_19", {16'd0, ref_elem(2, 0, 0)}, 32'd19);
        run_mul(2, 17, 1'b0);

        // N=1
        mem_a[0] = 8'd7;
        mem_b[0] = 8'd9;
        run_mul(1, 4, 1'b0);

        err_test(4'd0);
        err_test(4'd11);

        // N=3 with the background pattern
        run_mul(3, 3*3*5+1, 1'b0);

        // N=3 abort during the second element
        begin
            int we0;
            int done_seen;
            we0 = we_cnt;
            done_seen = 0;
            push_expect(3, 1);
            @(negedge clk);
            bus.size  = 4'd3;
            bus.start = 1'b1;
            @(posedge clk);
            #1 bus.start = 1'b0;
            repeat (7) @(posedge clk);
            #1 bus.abort = 1'b1;
            @(posedge clk);
            #1;
            chk("abort_busy", {31'd0, bus.busy}, 32'd0);
            chk("abort_rd_en", {31'd0, bus.rd_en}, 32'd0);
            chk("abort_res_we", {31'd0, bus.res_we}, 32'd0);
            bus.abort = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(posedge clk);
                #1;
                if (bus.done || bus.busy) done_seen++;
            end
            chk("abort_no_done", done_seen, 32'd0);
            chk("abort_one_write", we_cnt - we0, 32'd1);
            chk("abort_scoreboard", exp_q.size(), 32'd0);
        end
        mem_a[0] = 8'd1; mem_a[1] = 8'd2; mem_a[10] = 8'd3; mem_a[11] = 8'd4;
        mem_b[0] = 8'd5; mem_b[1] = 8'd6; mem_b[10] = 8'd7; mem_b[11] = 8'd8;
        run_mul(2, 17, 1'b0);

        // N=3 with asynchronous reset mid-run
        begin
            int we0;
            we0 = we_cnt;
            @(negedge clk);
            bus.size  = 4'd3;
            bus.start = 1'b1;
            @(posedge clk);
            #1 bus.start = 1'b0;
            repeat (2) @(posedge clk);
            #2 rst = 1'b1;
            #1;
            chk("async_reset_outputs", {bus.a_addr, bus.b_addr, bus.res_addr, bus.res_wdata,
                                        bus.rd_en, bus.res_we, bus.busy, bus.done, bus.err}, 32'd0);
            @(negedge clk);
            rst = 1'b0;
            chk("reset_no_writes", we_cnt - we0, 32'd0);
        end
        run_mul(2, 17, 1'b1);

        // N=10, all bytes 255
        for (int a = 0; a < 128; a++) begin
            mem_a[a] = 8'hFF;
            mem_b[a] = 8'hFF;
        end
`ifdef SATURATE_EN
        chk("ref_model_full", {16'd0, ref_elem(10, 0, 0)}, 32'h0000FFFF);
`else
        chk("ref_model_full", {16'd0, ref_elem(10, 0, 0)}, 32'h0000EC0A);
`endif
        run_mul(10, 1201, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
Sequences a single shared 8x8-bit multiply-accumulate over the i/j/k loops of an NxN matrix product (N = 1..MAX_N). Reads operands from the A and B matrix memories, which use 1-cycle registered reads. Writes each 16-bit result element to the result store, and reports busy, done and error to the control unit. It replaces the fully parallel multiplier with a time-multiplexed datapath.

Parameters:
MAX_N, 10, maximum matrix dimension; also the row stride of every memory (row-major)
ADDR_W, 7, memory address width (must hold MAX_N*MAX_N-1)
ACC_W, 16, accumulator and result width

Ports:
clk  input  1  system clock (bclk domain)
rst  input  1  asynchronous, active-high reset
start  input  1  begin a multiplication; sampled only in IDLE
size  input  4  matrix dimension N, latched on accepted start
abort  input  1  synchronous abort; return to IDLE
a_addr  output  ADDR_W  A read address = i*MAX_N + k
b_addr  output  ADDR_W  B read address = k*MAX_N + j
rd_en  output  1  read strobe for both memories
a_rdata  input  8  A data, valid the cycle after rd_en
b_rdata  input  8  B data, valid the cycle after rd_en
res_addr  output  ADDR_W  result address = i*MAX_N + j
res_wdata  output  ACC_W  result element
res_we  output  1  result write strobe, 1 cycle per element
busy  output  1  high from the cycle after an accepted start until done
done  output  1  1-cycle pulse when all N*N elements are written
err  output  1  1-cycle pulse on a rejected start

Behaviour:
- Reset (asynchronous): state IDLE; i, j, k, acc and the latched N all 0.
- Reset values of outputs: a_addr, b_addr and res_addr are 0. rd_en, res_we, busy, done and err are 0. res_wdata is 0.
- All outputs are registered.
- States: IDLE, RUN, DRAIN, WRITE, DONE.
- IDLE:
  - start=1 with 1<=size<=MAX_N: latch N; clear i, j, k and acc; go to RUN.
  - start=1 with size=0 or size>MAX_N: pulse err for 1 cycle and stay in IDLE.
- RUN:
  - Each cycle, issue addresses for the current k with rd_en=1.
  - If a read was issued in the previous cycle, acc += a_rdata*b_rdata.
  - When k=N-1 has been issued, go to DRAIN.
- DRAIN: rd_en=0; accumulate the final product; go to WRITE.
- WRITE:
  - res_we=1, res_wdata=acc, res_addr=i*MAX_N+j.
  - Clear acc and k.
  - Advance j; when j wraps from N-1 to 0, advance i.
  - After element (N-1,N-1), go to DONE; otherwise return to RUN.
- DONE: pulse done and drop busy in the same cycle; go to IDLE.
- Latency:
  - Each element takes N+2 cycles.
  - done is asserted N*N*(N+2)+1 cycles after the accepted start edge.
- Arithmetic:
  - Each product is 16 bits, unsigned.
  - The accumulator wraps modulo 2^ACC_W.
- start while busy is ignored, with no err pulse.
- size changes while busy are ignored; N stays latched.
- abort in any non-IDLE state:
  - Go to IDLE on the next edge.
  - rd_en, res_we and busy drop to 0; no done pulse.
  - No further result writes occur.
  - abort in IDLE has no effect.
- abort and start asserted in the same IDLE cycle: abort wins; start is ignored.
- res_we is never asserted in the same cycle as rd_en.
- rd_en is never asserted outside RUN.

Optional Feature:
SATURATE_EN:
- When defined: the accumulator saturates at 2^ACC_W-1. Once saturated it holds that value for the remainder of the element, and res_wdata is written as all ones.
- When undefined: wrap-around as specified above.

Test Plan:
- N=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]]:
  - Required writes: 19@0, 22@1, 43@10, 50@11, in that order.
  - done arrives 17 cycles after start.
  - busy is high throughout and low together with done.
- N=1, A[0]=7, B[0]=9: single write 63@0; done 4 cycles after start.
- size=0, and separately size=11:
  - err pulses 1 cycle.
  - busy stays 0, no rd_en, no res_we, state stays IDLE.
- N=10, all A and B bytes = 255:
  - 100 writes of 0xEC0A (650250 mod 65536) at addresses 0..99; done after 1201 cycles.
  - With SATURATE_EN defined: every write is 0xFFFF.
- N=3, abort asserted during the second element:
  - Exactly 1 res_we is seen; busy drops the next cycle; no done.
  - A fresh start with N=2 then completes correctly.
- N=3, rst pulsed mid-RUN:
  - All outputs are 0 immediately, without waiting for a clock.
  - After release, start with N=2 produces the correct 4 results.
  - A start pulse during busy in that run is ignored.
